// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the multiply/divide unit: op and state encodings, default width.
// Optional build macro MULDIV_FAST_MUL_EN selects the single-cycle multiplier.
package muldiv_unit_pkg;

  localparam int unsigned MULDIV_WORD_WIDTH = 32;

  localparam logic [2:0] MULDIV_OP_MULT  = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'b001;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'b010;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_MTHI  = 3'b100;
  localparam logic [2:0] MULDIV_OP_MTLO  = 3'b101;

  localparam logic [1:0] MULDIV_S_IDLE = 2'd0;
  localparam logic [1:0] MULDIV_S_RUN  = 2'd1;
  localparam logic [1:0] MULDIV_S_FIX  = 2'd2;

  // Only meaningful for the four mul/div encodings: even codes are the signed ops.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// Build macro MULDIV_FAST_MUL_EN does not change this interface.
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = MULDIV_WORD_WIDTH
);
  logic                  start;
  logic [2:0]            op;
  logic [WORD_WIDTH-1:0] opA;
  logic [WORD_WIDTH-1:0] opB;
  logic                  busy;
  logic                  done;
  logic [WORD_WIDTH-1:0] hi;
  logic [WORD_WIDTH-1:0] lo;

  modport master (output start, op, opA, opB, input busy, done, hi, lo);
  modport slave  (input start, op, opA, opB, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_iter_core.sv
// Iteration datapath: shift-add multiply / restoring divide on unsigned magnitudes.
// With MULDIV_FAST_MUL_EN defined, a multiply load writes the full product at once.
module muldiv_iter_core
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = MULDIV_WORD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic                    is_div_i,
  input  logic [WORD_WIDTH-1:0]   a_i,
  input  logic [WORD_WIDTH-1:0]   b_i,
  output logic [2*WORD_WIDTH-1:0] acc_o,
  output logic                    last_o
);

  localparam int unsigned CntW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [2*WORD_WIDTH-1:0] acc_q, acc_d;
  logic [WORD_WIDTH-1:0]   b_q, b_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH:0]     mul_sum;
  logic [WORD_WIDTH:0]     div_trial;

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    acc_d     = acc_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    mul_sum   = {1'b0, acc_q[2*WORD_WIDTH-1:WORD_WIDTH]} +
                {1'b0, (acc_q[0] ? b_q : {WORD_WIDTH{1'b0}})};
    div_trial = acc_q[2*WORD_WIDTH-1:WORD_WIDTH-1] - {1'b0, b_q};
    if (load_i) begin
      b_d   = b_i;
      cnt_d = '0;
`ifdef MULDIV_FAST_MUL_EN
      acc_d = is_div_i ? {{WORD_WIDTH{1'b0}}, a_i}
                       : ({{WORD_WIDTH{1'b0}}, a_i} * {{WORD_WIDTH{1'b0}}, b_i});
`else
      acc_d = {{WORD_WIDTH{1'b0}}, a_i};
`endif
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_i) begin
        if (!div_trial[WORD_WIDTH]) begin
          acc_d = {div_trial[WORD_WIDTH-1:0], acc_q[WORD_WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*WORD_WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {mul_sum, acc_q[WORD_WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CntW'(WORD_WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling, divide-by-zero bypass, MTHI/MTLO.
// Build macro MULDIV_FAST_MUL_EN: multiplies skip RUN and complete via FIX in two cycles.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = MULDIV_WORD_WIDTH
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  logic [1:0]              state_q, state_d;
  logic [WORD_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                    done_q, done_d;
  logic                    is_div_q, is_div_d;
  logic                    neg_q, neg_d;
  logic                    rem_neg_q, rem_neg_d;
  logic                    dz_q, dz_d;

  logic                    signed_op, a_neg, b_neg;
  logic [WORD_WIDTH-1:0]   a_mag, b_mag;
  logic                    core_load, core_en, core_div, core_last;
  logic [2*WORD_WIDTH-1:0] core_acc;
  logic [WORD_WIDTH-1:0]   quot, rem;

  assign signed_op = op_is_signed(bus.op);
  assign a_neg     = signed_op & bus.opA[WORD_WIDTH-1];
  assign b_neg     = signed_op & bus.opB[WORD_WIDTH-1];
  assign a_mag     = a_neg ? -bus.opA : bus.opA;
  assign b_mag     = b_neg ? -bus.opB : bus.opB;
  assign quot      = core_acc[WORD_WIDTH-1:0];
  assign rem       = core_acc[2*WORD_WIDTH-1:WORD_WIDTH];

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    core_load = 1'b0;
    core_en   = 1'b0;
    core_div  = is_div_q;
    case (state_q)
      MULDIV_S_IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            core_load = 1'b1;
            core_div  = bus.op[1];
            is_div_d  = bus.op[1];
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dz_d      = (bus.opB == '0);
`ifdef MULDIV_FAST_MUL_EN
            state_d   = bus.op[1] ? MULDIV_S_RUN : MULDIV_S_FIX;
`else
            state_d   = MULDIV_S_RUN;
`endif
          end else if (bus.op == MULDIV_OP_MTHI) begin
            hi_d = bus.opA;
          end else if (bus.op == MULDIV_OP_MTLO) begin
            lo_d = bus.opA;
          end
        end
      end
      MULDIV_S_RUN: begin
        core_en = 1'b1;
        if (core_last) state_d = MULDIV_S_FIX;
      end
      MULDIV_S_FIX: begin
        done_d  = 1'b1;
        state_d = MULDIV_S_IDLE;
        if (is_div_q) begin
          // Restoring divide by zero leaves quotient all-ones and remainder = |dividend|.
          lo_d = dz_q ? {WORD_WIDTH{1'b1}} : (neg_q ? -quot : quot);
          hi_d = rem_neg_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_q ? -core_acc : core_acc;
        end
      end
      default: state_d = MULDIV_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MULDIV_S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
    end
  end

  muldiv_iter_core #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (core_load),
    .en_i     (core_en),
    .is_div_i (core_div),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .acc_o    (core_acc),
    .last_o   (core_last)
  );

  assign bus.busy = (state_q != MULDIV_S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
- Sits downstream of the register file: consumes its two read-port operands (rs into opA, rt into opB) at the execute stage.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO for MFHI/MFLO, plus a busy flag the pipeline uses to stall HI/LO readers and new mul/div issues.

Parameters:
- WORD_WIDTH, 32, operand and HI/LO width. The iteration count equals WORD_WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  issue strobe, sampled at the rising edge
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- opA  in  WORD_WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
- opB  in  WORD_WIDTH  rt value (multiplier / divisor)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when HI/LO have just been updated by mul/div
- hi  out  WORD_WIDTH  HI register
- lo  out  WORD_WIDTH  LO register

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst).
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- Reset mid-operation: abort immediately and apply the reset values; no partial HI/LO write.
- States: IDLE, RUN, FIX. busy = (state != IDLE), decoded combinationally from state. done is registered.
- Issue acceptance: start is accepted only in IDLE. start while busy is ignored; the pipeline must stall on busy.
- MTHI / MTLO: accepted start writes opA to hi (MTHI) or lo (MTLO) at that edge. State stays IDLE, done stays 0, and the value is visible the next cycle.
- Mul/div issue (start in cycle 0, edge E0):
  - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned ops.
  - Latch result signs, the divisor-zero flag and the op; counter=0; go to RUN.
- RUN (cycles 1..WORD_WIDTH):
  - One iteration per edge.
  - Multiply: shift-add, 2*WORD_WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per edge.
  - After iteration WORD_WIDTH-1, go to FIX.
- FIX (cycle WORD_WIDTH+1): apply sign fixup, write hi/lo, go to IDLE.
- Result visibility: in cycle WORD_WIDTH+2 (cycle 34 for 32-bit), done=1, busy=0 and hi/lo hold new values. busy is high in cycles 1..33.
- Multiply result: {hi,lo} = full 2*WORD_WIDTH product. Signed: negate the 64-bit magnitude product iff the operand signs differ.
- Divide result: lo=quotient, hi=remainder. Signed: quotient negated iff the signs differ; remainder takes the dividend's sign.
- Divide by zero (opB==0, any signedness): completes with normal latency; hi=opA, lo={WORD_WIDTH{1'b1}}; no fixup.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap-around, no trap).
- opA/opB changes after the start edge have no effect; operands are latched.
- Inputs during FIX: start in FIX is ignored, even in the cycle busy is about to fall.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle full-width product.
  - Start edge E0 goes to FIX; hi/lo are written at E1; busy=1 in cycle 1 only; done=1 in cycle 2.
  - Division is unchanged.
- Undefined: multiply uses the WORD_WIDTH-iteration path described above.

Decomposition:
- Shared constants header (included like constants.v):
  - op encodings (MULDIV_OP_MULT … MULDIV_OP_MTLO)
  - state encodings (MULDIV_S_IDLE/RUN/FIX)
  - WORD_WIDTH default
- Sub-module muldiv_iter_core:
  - Holds the shift registers, accumulator/partial remainder and iteration counter.
  - Performs one mul or div step per enable; signals last-iteration.
- Top level keeps the FSM, sign/abs handling, divide-by-zero bypass, HI/LO registers and MTHI/MTLO.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → at cycle 34: hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle; busy high cycles 1..33.
- MULT 0xFFFFFFFD (−3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 → hi=100, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back → hi/lo updated the next cycle each; busy and done never assert. A second DIVU issued at cycle 5 of a running DIVU is ignored and the first result is intact.
- Assert rst at cycle 10 of a MULTU with hi/lo previously 0xAAAA/0x5555 → next cycle hi=lo=0, busy=0, no done pulse; a fresh DIVU 9/4 afterwards → lo=2, hi=1.
- With MULDIV_FAST_MUL_EN: MULTU 6×7 → lo=42, hi=0 in cycle 2, busy only cycle 1; DIVU latency unchanged (34).
